// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bridge state encoding and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: counts ACCESS wait cycles. The tc output flags the last
// wait cycle the bridge tolerates before aborting.
module apb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic pclk,
    input  logic prstn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned     CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == TC_VAL);

    // Next count: clear wins, otherwise count wait cycles and saturate at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command channel to a single APB transfer,
// result returned on a valid/ready response channel. All outputs registered.
// Optional macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pselx,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    apb_state_e            state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic                  pselx_q,     pselx_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  timeout_hit;

`ifdef APB_TIMEOUT_EN
    logic to_tc;

    apb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .pclk  (pclk),
        .prstn (prstn),
        .clr   (state_q == ST_SETUP),
        .en    ((state_q == ST_ACCESS) && !pready),
        .tc    (to_tc)
    );

    assign timeout_hit = (state_q == ST_ACCESS) && to_tc;
`else
    assign timeout_hit = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign paddr     = paddr_q;
    assign pselx     = pselx_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;

    // Next state and next registered outputs; everything holds unless a transition changes it.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        paddr_d     = paddr_q;
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    pselx_d     = 1'b1;
                    penable_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                pselx_d   = 1'b1;
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready slave wins over a timeout landing in the same cycle.
                if (pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                pselx_d     = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            pselx_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            paddr_q     <= paddr_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
        end
    end

endmodule
